// File: rtl/uart_rx_byte_pkg.sv
// Shared UART definitions: receiver states, byte type, baud constants.
// Used by both the receiver and the transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } uart_rx_state_t;

   typedef logic [7:0] uart_byte_t;

   localparam int BAUD_DEFAULT = 115200;

   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_rx_byte_sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
// The reset value is a parameter so that idle-high pins come out of reset idle.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_byte.sv
// UART byte receiver (8N1, LSB first) with a valid/ready output.
// Define UART_RX_PARITY_EN to switch to 8E1 with a parity check.
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLK_HZ       = 24000000,
   parameter int BAUD         = BAUD_DEFAULT,
   parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
   input  logic       pll_clk,
   input  logic       rst,
   input  logic       rx_in,
   output logic [7:0] data_out,
   output logic       data_valid,
   input  logic       data_ready,
   output logic       frame_err,
   output logic       overrun_err,
   output logic       parity_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   logic           rxs;
   uart_rx_state_t state;
   logic [CW-1:0]  cnt;
   logic [2:0]     idx;
   uart_byte_t     shreg;
   logic           par_ok;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk (pll_clk),
      .rst (rst),
      .d   (rx_in),
      .q   (rxs)
   );

`ifdef UART_RX_PARITY_EN
   logic par_bit;
   logic parity_err_q;
   assign par_ok     = (par_bit == ^shreg);
   assign parity_err = parity_err_q;
`else
   assign par_ok     = 1'b1;
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge pll_clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         idx         <= '0;
         shreg       <= '0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit      <= 1'b0;
         parity_err_q <= 1'b0;
`endif
      end else begin
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
         // A later delivery in the same cycle overrides this clear.
         if (data_valid && data_ready)
            data_valid <= 1'b0;

         case (state)
            IDLE: begin
               cnt <= '0;
               if (!rxs)
                  state <= START;
            end
            START: begin
               if (cnt == HALF_M1) begin
                  cnt   <= '0;
                  idx   <= '0;
                  state <= rxs ? IDLE : DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == FULL_M1) begin
                  cnt        <= '0;
                  shreg[idx] <= rxs;
                  idx        <= idx + 1'b1;
                  if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cnt == FULL_M1) begin
                  cnt     <= '0;
                  par_bit <= rxs;
                  state   <= STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (cnt == FULL_M1) begin
                  cnt <= '0;
                  if (!rxs) begin
                     // Framing error wins over overrun and parity.
                     frame_err <= 1'b1;
                     state     <= WAIT_HIGH;
                  end else begin
                     state <= IDLE;
                     if (!par_ok) begin
`ifdef UART_RX_PARITY_EN
                        parity_err_q <= 1'b1;
`endif
                     end else if (data_valid && !data_ready) begin
                        overrun_err <= 1'b1;
                     end else begin
                        data_out   <= shreg;
                        data_valid <= 1'b1;
                     end
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_HIGH: begin
               cnt <= '0;
               if (rxs)
                  state <= IDLE;
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
